snoop_responder: RTL
====================

Name: snoop_responder

Overview:
- Bus-side half of the MSI snooping cache controller. Observes bus messages issued by other caches and updates the local per-line coherence state.
- Requests a block writeback when a remote miss hits a locally exclusive (dirty) line, and tells memory to abort its own response in that case.
- Holds the line-state array and gives the CPU-side controller a read port and a write port into it.

Parameters:
- IDX_W, 3, width of cache line index (LINES = 2**IDX_W)
- RESET_STATE, 2'b00, state loaded into every line on reset (00 invalid, 01 shared, 10 exclusive)
- CNT_W, 16, width of statistics counters (used only with SNOOP_STATS_EN)

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- snoop_valid  in  1  bus message present
- snoop_ready  out  1  responder can accept a message
- snoop_msg  in  3  001 read miss, 010 write miss, 011 invalidate; others are no-op
- snoop_index  in  IDX_W  line index of snooped address
- snoop_done  out  1  one-cycle pulse: message fully processed
- abort_mem  out  1  one-cycle pulse: memory must abort its response, local cache supplies data
- wb_req  out  1  writeback request, held until acknowledged
- wb_index  out  IDX_W  line being written back, stable while wb_req=1
- wb_ack  in  1  memory accepted writeback
- proto_err  out  1  one-cycle pulse: invalidate received for an exclusive line
- cpu_wr_en  in  1  CPU-side state update strobe
- cpu_wr_index  in  IDX_W  line to update
- cpu_wr_state  in  2  new state; 11 is ignored
- cpu_wr_nack  out  1  registered pulse: CPU update dropped due to conflict
- rd_index  in  IDX_W  CPU-side lookup index
- rd_state  out  2  combinational state of line rd_index

Behaviour:
- Reset:
  - all lines = RESET_STATE
  - FSM = IDLE
  - snoop_ready=1
  - snoop_done, abort_mem, wb_req, proto_err, cpu_wr_nack = 0
  - wb_index=0
- Reset mid-operation aborts any pending writeback immediately: wb_req drops asynchronously with reset.
- FSM states: IDLE, LOOKUP, WRITEBACK.
- IDLE:
  - snoop_ready=1.
  - Handshake: snoop_valid&snoop_ready at edge T latches msg and index, then moves to LOOKUP.
- LOOKUP (one cycle, snoop_ready=0). Action taken at edge T+1 depends on the state of the latched line:
  - invalid, any msg: no change, snoop_done pulses, go to IDLE.
  - shared + read miss: stays shared, snoop_done pulses, go to IDLE.
  - shared + write miss or invalidate: becomes invalid, snoop_done pulses, go to IDLE.
  - exclusive + read miss or write miss: abort_mem pulses, wb_req=1, wb_index=line, go to WRITEBACK.
  - exclusive + invalidate: becomes invalid, proto_err and snoop_done pulse, no writeback, go to IDLE.
  - msg 000 or 1xx: no state change, snoop_done pulses, go to IDLE.
- WRITEBACK:
  - wb_req held until wb_ack is sampled high.
  - On that edge: wb_req=0, line becomes shared (read miss) or invalid (write miss), snoop_done pulses, go to IDLE.
  - wb_ack outside WRITEBACK is ignored.
  - wb_ack in the same cycle wb_req first rises is not possible (wb_req is registered).
- Latency:
  - no writeback: snoop_done high in cycle T+2 (registered), i.e. 2 cycles after accept
  - writeback: snoop_done in the cycle after the edge where wb_ack is sampled
- Throughput: one message per 2 cycles minimum. A message is held off (snoop_ready=0) until the FSM is back in IDLE.
- CPU write port:
  - Applied at the rising edge when cpu_wr_en=1 and cpu_wr_state!=11.
  - Conflict: if cpu_wr_index equals the index of a line the FSM updates at the same edge, or the line held in WRITEBACK, the snoop wins. The CPU write is dropped and cpu_wr_nack pulses in the next cycle.
  - A CPU write to any other index proceeds in parallel.
- rd_state reflects the array contents after the most recent edge (no bypass of same-edge writes).
- Outputs snoop_done, abort_mem, proto_err, cpu_wr_nack are single-cycle pulses.

Optional Feature:
- Macro SNOOP_STATS_EN.
- When defined:
  - adds outputs hit_count[CNT_W-1:0] and wb_count[CNT_W-1:0], both reset to 0
  - hit_count increments on every LOOKUP where the line is non-invalid
  - wb_count increments on each wb_ack accepted in WRITEBACK
  - both saturate at all-ones
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_STATE=01 -> rd_state=01 for all 8 indexes; snoop_ready=1; all pulses 0.
- Line 3 shared, snoop write miss idx 3 accepted at T -> snoop_done=1 at T+2, rd_state(3)=00, abort_mem never asserted.
- Line 5 exclusive, snoop read miss idx 5 -> abort_mem pulse and wb_req=1 with wb_index=5. wb_ack delayed 4 cycles -> wb_req stays high throughout, then rd_state(5)=01 and snoop_done pulses once.
- Line 2 exclusive, snoop invalidate idx 2 -> proto_err and snoop_done pulse together, rd_state(2)=00, wb_req stays 0.
- Line 4 in WRITEBACK, cpu_wr_en with index 4, state 10 -> cpu_wr_nack pulses next cycle, line keeps the snoop result. Same cycle, a CPU write to idx 1 with state 01 -> rd_state(1)=01.
- Reset asserted while wb_req=1 -> wb_req drops immediately, all lines = RESET_STATE, next snoop accepted normally. With SNOOP_STATS_EN: prior hit_count/wb_count clear to 0.

Source files
------------

// File: rtl/snoop_responder.sv
// snoop_responder
//   Bus-side half of an MSI snooping cache controller. Watches bus messages
//   issued by other caches, updates the local per-line coherence state, and
//   requests a writeback when a remote miss hits a locally exclusive line.
//   Owns the line-state array and exposes a CPU-side read port and write port.
//
// Line states: 00 invalid, 01 shared, 10 exclusive.
// Bus messages: 001 read miss, 010 write miss, 011 invalidate, others no-op.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   snoop_valid/ready/msg/index  bus message handshake
//   snoop_done                   pulse: message fully processed
//   abort_mem                    pulse: memory must abort, local cache supplies
//   wb_req/wb_index/wb_ack       writeback request held until acknowledged
//   proto_err                    pulse: invalidate seen on an exclusive line
//   cpu_wr_en/index/state        CPU-side state update (state 11 ignored)
//   cpu_wr_nack                  pulse: CPU update dropped, snoop owned line
//   rd_index/rd_state            combinational CPU-side lookup
//
// Optional feature macro SNOOP_STATS_EN: adds saturating hit_count and
// wb_count outputs of CNT_W bits.
module snoop_responder #(
  parameter int         IDX_W       = 3,
  parameter logic [1:0] RESET_STATE = 2'b00,
  parameter int         CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             snoop_valid,
  output logic             snoop_ready,
  input  logic [2:0]       snoop_msg,
  input  logic [IDX_W-1:0] snoop_index,
  output logic             snoop_done,
  output logic             abort_mem,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_index,
  input  logic             wb_ack,
  output logic             proto_err,
  input  logic             cpu_wr_en,
  input  logic [IDX_W-1:0] cpu_wr_index,
  input  logic [1:0]       cpu_wr_state,
  output logic             cpu_wr_nack,
  input  logic [IDX_W-1:0] rd_index,
  output logic [1:0]       rd_state
`ifdef SNOOP_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  localparam int LINES = 1 << IDX_W;

  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_EX  = 2'b10;

  localparam logic [2:0] MSG_RD_MISS = 3'b001;
  localparam logic [2:0] MSG_WR_MISS = 3'b010;
  localparam logic [2:0] MSG_INVAL   = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK} state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       lines [LINES];
  logic [2:0]       msg_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       line_cur;

  logic             done_nxt, abort_nxt, proto_nxt, nack_nxt;
  logic             wb_set, wb_clr, fsm_we, hit, ack_take;
  logic [1:0]       fsm_wdata;
  logic             msg_known, cpu_apply, conflict, cpu_we;

  assign snoop_ready = (state_q == S_IDLE);
  assign rd_state    = lines[rd_index];
  assign line_cur    = lines[idx_p0];
  assign msg_known   = (msg_p0 == MSG_RD_MISS) || (msg_p0 == MSG_WR_MISS) ||
                       (msg_p0 == MSG_INVAL);

  // Stage p0: accepted message captured on the handshake edge
  always_ff @(posedge clock) begin
    if (snoop_valid && snoop_ready) begin
      msg_p0 <= snoop_msg;
      idx_p0 <= snoop_index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    proto_nxt = 1'b0;
    wb_set    = 1'b0;
    wb_clr    = 1'b0;
    fsm_we    = 1'b0;
    fsm_wdata = ST_INV;
    hit       = 1'b0;
    ack_take  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (snoop_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
        hit       = (line_cur == ST_SH) || (line_cur == ST_EX);
        if (msg_known) begin
          if (line_cur == ST_SH) begin
            fsm_we = (msg_p0 != MSG_RD_MISS);
          end else if (line_cur == ST_EX) begin
            if (msg_p0 == MSG_INVAL) begin
              // Another cache should never invalidate a line we own dirty.
              fsm_we    = 1'b1;
              proto_nxt = 1'b1;
            end else begin
              done_nxt  = 1'b0;
              abort_nxt = 1'b1;
              wb_set    = 1'b1;
              state_nxt = S_WRITEBACK;
            end
          end
        end
      end
      S_WRITEBACK: begin
        if (wb_ack) begin
          ack_take  = 1'b1;
          wb_clr    = 1'b1;
          fsm_we    = 1'b1;
          fsm_wdata = (msg_p0 == MSG_RD_MISS) ? ST_SH : ST_INV;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The snoop owns its line on any edge it writes it and for the whole
  // writeback; a CPU update to that line is dropped and nacked.
  assign cpu_apply = cpu_wr_en && (cpu_wr_state != 2'b11);
  assign conflict  = (fsm_we && (cpu_wr_index == idx_p0)) ||
                     ((state_q == S_WRITEBACK) && (cpu_wr_index == wb_index));
  assign cpu_we    = cpu_apply && !conflict;
  assign nack_nxt  = cpu_apply && conflict;

  // Stage p1: registered responses and line-state array update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) lines[i] <= RESET_STATE;
      snoop_done  <= 1'b0;
      abort_mem   <= 1'b0;
      proto_err   <= 1'b0;
      cpu_wr_nack <= 1'b0;
      wb_req      <= 1'b0;
      wb_index    <= '0;
    end else begin
      snoop_done  <= done_nxt;
      abort_mem   <= abort_nxt;
      proto_err   <= proto_nxt;
      cpu_wr_nack <= nack_nxt;
      if (wb_set) begin
        wb_req   <= 1'b1;
        wb_index <= idx_p0;
      end else if (wb_clr) begin
        wb_req <= 1'b0;
      end
      if (fsm_we) lines[idx_p0]       <= fsm_wdata;
      if (cpu_we) lines[cpu_wr_index] <= cpu_wr_state;
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
      wb_count  <= '0;
    end else begin
      if (hit && (hit_count != '1))     hit_count <= hit_count + 1'b1;
      if (ack_take && (wb_count != '1)) wb_count  <= wb_count + 1'b1;
    end
  end
`endif

endmodule
